// File: rtl/display_frame_buffer.sv
// Double-buffered hex frame store for an 8-digit 7-segment display.
// New words are swapped in only at a scan-frame boundary or after a scan stall.
module display_frame_buffer #(
    parameter int STALL_CYCLES = 1_000_000,
    parameter int TMR_W        = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  seg_sel,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        commit
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HELD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0] STALL_LIM = TMR_W'(STALL_CYCLES - 1);

    state_t      state, state_n;
    logic [2:0]  sel_m, sel_s, sel_p;
    logic        sel_chg, boundary, stall;
    logic [TMR_W-1:0] cnt;
    logic [31:0] pend, act;
    logic [7:0]  pend_dp, act_dp;
    logic        cap, load;
    logic [31:0] upper;
    logic [3:0]  nib;
    logic        blanked;

    // seg_sel comes from another clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_m <= 3'b000;
            sel_s <= 3'b000;
            sel_p <= 3'b000;
        end else begin
            sel_m <= seg_sel;
            sel_s <= sel_m;
            sel_p <= sel_s;
        end
    end

    assign sel_chg  = (sel_s != sel_p);
    assign boundary = sel_chg && (sel_s == 3'b000);
    assign stall    = (cnt >= STALL_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (sel_chg)
            cnt <= '0;
        else if (cnt != '1)
            cnt <= cnt + TMR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= EMPTY;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        wr_ready = 1'b0;
        commit   = 1'b0;
        cap      = 1'b0;
        load     = 1'b0;
        unique case (state)
            EMPTY: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    cap     = 1'b1;
                    state_n = HELD;
                end
            end
            HELD: begin
                if (boundary || stall) begin
                    load    = 1'b1;
                    state_n = COMMIT;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_n = EMPTY;
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend    <= '0;
            pend_dp <= '0;
            act     <= '0;
            act_dp  <= '0;
        end else begin
            if (cap) begin
                pend    <= wr_data;
                pend_dp <= wr_dp;
            end
            if (load) begin
                act    <= pend;
                act_dp <= pend_dp;
            end
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] c;
        unique case (n)
            4'h0: c = 7'b1000000;
            4'h1: c = 7'b1111001;
            4'h2: c = 7'b0100100;
            4'h3: c = 7'b0110000;
            4'h4: c = 7'b0011001;
            4'h5: c = 7'b0010010;
            4'h6: c = 7'b0000010;
            4'h7: c = 7'b1111000;
            4'h8: c = 7'b0000000;
            4'h9: c = 7'b0010000;
            4'hA: c = 7'b0001000;
            4'hB: c = 7'b0000011;
            4'hC: c = 7'b1000110;
            4'hD: c = 7'b0100001;
            4'hE: c = 7'b0000110;
            4'hF: c = 7'b0001110;
        endcase
        return c;
    endfunction

    // a digit is blank when it and every more-significant nibble are zero
    assign upper   = act >> {sel_s, 2'b00};
    assign nib     = act[{sel_s, 2'b00} +: 4];
    assign blanked = blank_lz && (sel_s != 3'b000) && (upper == 32'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            seg <= blanked ? 7'b1111111 : hex7(nib);
            dp  <= ~act_dp[sel_s];
        end
    end

endmodule
